// File: rtl/pe_mul_arbiter.sv
// Purpose : round-robin arbiter sharing one pipelined 15u x 7s multiplier among N_REQ requesters.
// Latency : MUL_LATENCY cycles from grant to rsp_valid, plus one cycle per stall cycle.
// Backpressure: rsp_valid & ~rsp_ready freezes the multiplier (mul_ce=0) and the tag pipeline, and blocks new grants.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req_valid/req_ready     per-requester handshake; req_a[15i+:15] unsigned, req_b[7i+:7] signed
//   mul_ce/din0/din1/dout   external multiplier (MUL_LATENCY ce-qualified stages, no reset)
//   rsp_valid/ready/tag/data shared response channel, data = mul_dout
//   busy, inflight          occupancy of the shadow valid pipeline
module pe_mul_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TAG_W       = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [15*N_REQ-1:0]    req_a,
    input  logic [7*N_REQ-1:0]     req_b,
    output logic                   mul_ce,
    output logic [14:0]            mul_din0,
    output logic [6:0]             mul_din1,
    input  logic [21:0]            mul_dout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic [21:0]            rsp_data,
    output logic                   busy,
    output logic [2:0]             inflight
);

    localparam logic [TAG_W:0]   NREQ_W   = (TAG_W+1)'(N_REQ);
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(N_REQ - 1);

    // Shadow pipeline: valid bit and requester tag per multiplier stage.
    logic [MUL_LATENCY-1:0] sv_q, sv_d;
    logic [TAG_W-1:0]       stag_q [MUL_LATENCY];
    logic [TAG_W-1:0]       stag_d [MUL_LATENCY];
    logic [TAG_W-1:0]       ptr_q, ptr_d;

    // Operand hold registers keep the multiplier inputs quiet between grants.
    logic [14:0]            din0_q;
    logic [6:0]             din1_q;

    logic                   stall;
    logic                   gnt_vld;
    logic [TAG_W-1:0]       gnt_idx;
    logic [TAG_W:0]         scan_sum;
    logic [14:0]            sel_a;
    logic [6:0]             sel_b;
    logic [2:0]             occ;

    // A response waiting at the last stage with no taker is the only stall source.
    assign stall  = sv_q[MUL_LATENCY-1] & ~rsp_ready;
    assign mul_ce = reset_n & ~stall;

    // Round-robin scan starting at ptr_q, wrapping modulo N_REQ.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (scan_sum >= NREQ_W) begin
                scan_sum = scan_sum - NREQ_W;
            end
            if (!gnt_vld && req_valid[scan_sum[TAG_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_sum[TAG_W-1:0];
            end
        end
        if (stall || !reset_n) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == TAG_W'(i)) begin
                req_ready[i] = gnt_vld;
                sel_a        = req_a[15*i +: 15];
                sel_b        = req_b[7*i +: 7];
            end
        end
    end

    assign mul_din0 = gnt_vld ? sel_a : din0_q;
    assign mul_din1 = gnt_vld ? sel_b : din1_q;

    // Every grant is a transfer: ready is only raised toward a valid requester.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + TAG_W'(1);
        end
    end

    // Shadow pipeline moves in lockstep with the multiplier's ce.
    always_comb begin
        sv_d = sv_q;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            stag_d[k] = stag_q[k];
        end
        if (mul_ce) begin
            sv_d[0]   = gnt_vld;
            stag_d[0] = gnt_idx;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                sv_d[k]   = sv_q[k-1];
                stag_d[k] = stag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sv_q  <= '0;
            ptr_q <= '0;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                stag_q[k] <= '0;
            end
        end else begin
            sv_q  <= sv_d;
            ptr_q <= ptr_d;
            for (int k = 0; k < MUL_LATENCY; k++) begin
                stag_q[k] <= stag_d[k];
            end
        end
    end

    // Datapath hold registers: contents are don't-care while no grant is valid.
    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            din0_q <= sel_a;
            din1_q <= sel_b;
        end
    end

    always_comb begin
        occ = '0;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            occ = occ + {2'b00, sv_q[k]};
        end
    end

    assign inflight  = occ;
    assign busy      = |sv_q;
    assign rsp_valid = sv_q[MUL_LATENCY-1];
    assign rsp_tag   = stag_q[MUL_LATENCY-1];
    assign rsp_data  = mul_dout;

endmodule

// File: tb/tb_pe_mul_arbiter.sv
module tb_pe_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [59:0] req_a;
    logic [27:0] req_b;
    logic        mul_ce;
    logic [14:0] mul_din0;
    logic [6:0]  mul_din1;
    logic [21:0] mul_dout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_tag;
    logic [21:0] rsp_data;
    logic        busy;
    logic [2:0]  inflight;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  tag;
        logic [21:0] data;
    } exp_t;

    exp_t exp_q [$];

    always #5 clk = ~clk;

    pe_mul_arbiter #(.N_REQ(4), .TAG_W(2), .MUL_LATENCY(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .inflight  (inflight)
    );

    // External multiplier: three ce-qualified stages, no reset.
    logic [21:0] m0, m1, m2;
    always @(posedge clk) begin
        if (mul_ce) begin
            m0 <= $signed({1'b0, mul_din0}) * $signed(mul_din1);
            m1 <= m0;
            m2 <= m1;
        end
    end
    assign mul_dout = m2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [14:0] a, input logic [6:0] b);
        req_a[15*i +: 15] = a;
        req_b[7*i +: 7]   = b;
    endtask

    task automatic push(input logic [1:0] t, input logic [21:0] d);
        exp_t e;
        e.tag  = t;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted response is popped and compared.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got tag=%0d data=%h expected no response", rsp_tag, rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rsp_tag !== e.tag || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL rsp_match: got tag=%0d data=%h expected tag=%0d data=%h",
                             rsp_tag, rsp_data, e.tag, e.data);
                end
            end
        end
    end

    logic [14:0] ex_a [3] = '{15'd32767, 15'd32767, 15'd0};
    logic [6:0]  ex_b [3] = '{7'h40, 7'h3F, 7'h7F};
    logic [21:0] ex_d [3] = '{22'h200040, 22'h1F7FC1, 22'h000000};
    logic [14:0] rr_a [4] = '{15'd10, 15'd200, 15'd3000, 15'd32767};
    logic [6:0]  rr_b [4] = '{7'd5, 7'h79, 7'h40, 7'd1};
    logic [21:0] rr_d [4] = '{22'h000032, 22'h3FFA88, 22'h3D1200, 22'h007FFF};
    logic [14:0] bp_a [3] = '{15'd7, 15'd9, 15'd11};
    logic [6:0]  bp_b [3] = '{7'd3, 7'h7E, 7'd4};
    logic [21:0] bp_d [3] = '{22'h000015, 22'h3FFFEE, 22'h00002C};

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state, with all requesters asking.
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_busy", busy, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_mul_ce", mul_ce, 0);
        cyc();
        reset_n   = 1'b1;
        req_valid = 4'h0;

        // Single op: 100 * -3 = -300.
        cyc();
        set_op(0, 15'd100, 7'h7D);
        req_valid = 4'b0001;
        push(2'd0, 22'h3FFED4);
        @(negedge clk);
        chk("single_grant", req_ready, 4'b0001);
        chk("single_din0", mul_din0, 100);
        chk("single_din1", mul_din1, 7'h7D);
        cyc();
        req_valid = 4'h0;
        @(negedge clk);
        chk("single_ready_drop", req_ready, 0);
        chk("single_inflight1", inflight, 1);
        chk("single_lat1", rsp_valid, 0);
        cyc();
        @(negedge clk);
        chk("single_lat2", rsp_valid, 0);
        cyc();
        @(negedge clk);
        chk("single_lat3", rsp_valid, 1);
        chk("single_tag", rsp_tag, 0);
        chk("single_data", rsp_data, 22'h3FFED4);
        cyc();
        @(negedge clk);
        chk("single_inflight0", inflight, 0);
        chk("single_busy0", busy, 0);

        // Extremes, back to back on requester 3.
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_op(3, ex_a[k], ex_b[k]);
            req_valid = 4'b1000;
            push(2'd3, ex_d[k]);
            @(negedge clk);
            chk("ext_grant", req_ready, 4'b1000);
        end
        cyc();
        req_valid = 4'h0;
        repeat (4) cyc();

        // Round-robin with all four requesters valid for 8 cycles.
        for (int i = 0; i < 4; i++) set_op(i, rr_a[i], rr_b[i]);
        for (int k = 0; k < 11; k++) begin
            cyc();
            req_valid = (k < 8) ? 4'hF : 4'h0;
            if (k < 8) push(2'(k % 4), rr_d[k % 4]);
            @(negedge clk);
            chk("rr_grant", req_ready, (k < 8) ? (32'd1 << (k % 4)) : 32'd0);
            if (k >= 3) chk("rr_rsp_valid", rsp_valid, 1);
        end
        cyc();
        @(negedge clk);
        chk("rr_drained", rsp_valid, 0);

        // Back-pressure: three ops on requester 1, then 5 stalled cycles.
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_op(1, bp_a[k], bp_b[k]);
            req_valid = 4'b0010;
            push(2'd1, bp_d[k]);
            @(negedge clk);
            chk("bp_grant", req_ready, 4'b0010);
        end
        cyc();
        req_valid = 4'b0100;
        set_op(2, 15'd1, 7'd1);
        push(2'd2, 22'h000001);
        rsp_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) cyc();
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_tag", rsp_tag, 1);
            chk("bp_rsp_data", rsp_data, 22'h000015);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_mul_ce", mul_ce, 0);
            chk("bp_inflight", inflight, 3);
        end
        cyc();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", req_ready, 4'b0100);
        chk("bp_release_ce", mul_ce, 1);
        chk("bp_release_rsp0", rsp_valid, 1);
        cyc();
        req_valid = 4'h0;
        @(negedge clk);
        chk("bp_release_rsp1", rsp_valid, 1);
        cyc();
        @(negedge clk);
        chk("bp_release_rsp2", rsp_valid, 1);
        cyc();
        @(negedge clk);
        chk("bp_release_rsp3", rsp_valid, 1);
        cyc();
        @(negedge clk);
        chk("bp_release_done", rsp_valid, 0);

        // Reset with two ops in flight; those ops must vanish.
        cyc();
        set_op(2, 15'd50, 7'd3);
        req_valid = 4'b0100;
        @(negedge clk);
        chk("rst_op_grant0", req_ready, 4'b0100);
        cyc();
        set_op(2, 15'd60, 7'd3);
        @(negedge clk);
        chk("rst_op_grant1", req_ready, 4'b0100);
        cyc();
        req_valid = 4'h0;
        @(negedge clk);
        chk("rst_inflight2", inflight, 2);
        #1;
        reset_n   = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_inflight0", inflight, 0);
        chk("rst_mul_ce", mul_ce, 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n   = 1'b1;
        req_valid = 4'b1010;
        set_op(1, 15'd5, 7'd5);
        set_op(3, 15'd9, 7'd9);
        push(2'd1, 22'h000019);
        @(negedge clk);
        chk("rst_ptr_grant", req_ready, 4'b0010);
        cyc();
        req_valid = 4'h0;
        repeat (6) cyc();
        @(negedge clk);
        chk("rst_busy_after", busy, 0);

        // Bubbles: requester 2 valid on alternate cycles.
        for (int k = 0; k < 11; k++) begin
            cyc();
            req_valid = (k < 8 && (k % 2) == 0) ? 4'b0100 : 4'h0;
            set_op(2, 15'(100 * (k / 2 + 1)), 7'd2);
            if (k < 8 && (k % 2) == 0) push(2'd2, 22'(200 * (k / 2 + 1)));
            @(negedge clk);
            chk("bub_mul_ce", mul_ce, 1);
            chk("bub_grant", req_ready, (k < 8 && (k % 2) == 0) ? 32'h4 : 32'h0);
            chk("bub_rsp_valid", rsp_valid, (k >= 3 && k <= 9 && ((k - 3) % 2) == 0) ? 32'd1 : 32'd0);
        end

        // Bounded drain of any outstanding expectations.
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) cyc();
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
